velocity_estimator: RTL and testbench

Converts the signed 32-bit quadrature position count into a windowed, moving-averaged velocity for the coms block's `velocity` field and the motor controller's damping term. Sits directly downstream of the quad encoder counter. Each window of 2^WINDOW_LOG2 clocks produces one position delta; the last 2^AVG_LOG2 deltas are averaged with a ring buffer and a running sum.

---
 rtl/motor_pkg.sv | 15 +
 rtl/velocity_avg_ring.sv | 68 ++++++
 rtl/velocity_estimator.sv | 94 +++++++++
 tb/tb_velocity_estimator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared motor-control constants and types.
// Widths, default estimator params, FSM states.
package motor_pkg;

  localparam int POS_W = 32;
  localparam int VEL_W = 32;
  localparam int DEFAULT_WINDOW_LOG2 = 14;
  localparam int DEFAULT_AVG_LOG2 = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } est_state_e;

endpackage

// File: rtl/velocity_avg_ring.sv
// Ring-buffer moving average of window deltas.
// push/din in; avg (sum>>>AVG_LOG2) + avg_valid out.
module velocity_avg_ring
  import motor_pkg::*;
#(
  parameter int AVG_LOG2 = DEFAULT_AVG_LOG2
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic signed [POS_W-1:0] din,
  output logic signed [VEL_W-1:0] avg,
  output logic                    avg_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW = POS_W + AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic signed [POS_W-1:0] ring_q [DEPTH];
  logic [PW-1:0]           wp_q;
  logic [PW-1:0]           wp_d;
  logic signed [SW-1:0]    sum_q;
  logic signed [SW-1:0]    sum_d;
  logic signed [SW-1:0]    shifted;
  logic                    stage_q;
  logic signed [VEL_W-1:0] avg_q;
  logic                    avg_valid_q;

  // Oldest entry leaves the sum as the new one enters.
  always_comb begin
    sum_d = sum_q + SW'(din) - SW'(ring_q[wp_q]);
    wp_d = (DEPTH == 1) ? '0 : wp_q + PW'(1);
    shifted = sum_q >>> AVG_LOG2;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wp_q <= '0;
      sum_q <= '0;
      stage_q <= 1'b0;
      avg_q <= '0;
      avg_valid_q <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wp_q <= '0;
      sum_q <= '0;
      stage_q <= 1'b0;
      avg_q <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      stage_q <= push;
      avg_valid_q <= stage_q;
      if (push) begin
        sum_q <= sum_d;
        ring_q[wp_q] <= din;
        wp_q <= wp_d;
      end
      if (stage_q) avg_q <= shifted[VEL_W-1:0];
    end
  end

  assign avg = avg_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: rtl/velocity_estimator.sv
// Windowed, moving-averaged velocity from encoder count.
// CLK/reset/enable/clear/position in; velocity/delta/valid out.
module velocity_estimator
  import motor_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
  parameter int AVG_LOG2 = DEFAULT_AVG_LOG2
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic signed [POS_W-1:0] position,
  output logic signed [VEL_W-1:0] velocity,
  output logic signed [POS_W-1:0] delta,
  output logic                    valid
);

  est_state_e state_q;
  est_state_e state_d;

  logic [WINDOW_LOG2-1:0]  wcnt_q;
  logic signed [POS_W-1:0] prev_q;
  logic signed [POS_W-1:0] d_q;
  logic signed [POS_W-1:0] delta_q;
  logic                    push_q;
  logic                    s2_q;
  logic                    tc;

  always_comb begin
    state_d = state_q;
    tc = 1'b0;
    unique case (state_q)
      IDLE: if (enable && !clear) state_d = RUN;
      RUN: begin
        if (!enable) state_d = IDLE;
        tc = enable && !clear && (&wcnt_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      prev_q <= '0;
      d_q <= '0;
      delta_q <= '0;
      push_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q <= tc;
      // Stages already in flight finish even if enable drops.
      s2_q <= push_q && !clear;
      if (clear) begin
        wcnt_q <= '0;
        prev_q <= position;
        delta_q <= '0;
      end else begin
        if (state_q == IDLE) begin
          wcnt_q <= '0;
          if (enable) prev_q <= position;
        end else if (!enable) begin
          wcnt_q <= '0;
        end else begin
          wcnt_q <= wcnt_q + WINDOW_LOG2'(1);
        end
        // Modulo-2^32 subtraction handles counter wrap.
        if (tc) begin
          d_q <= position - prev_q;
          prev_q <= position;
        end
        if (s2_q) delta_q <= d_q;
      end
    end
  end

  velocity_avg_ring #(
    .AVG_LOG2(AVG_LOG2)
  ) u_ring (
    .CLK      (CLK),
    .reset    (reset),
    .clear    (clear),
    .push     (push_q),
    .din      (d_q),
    .avg      (velocity),
    .avg_valid(valid)
  );

  assign delta = delta_q;

endmodule

// File: tb/tb_velocity_estimator.sv
// Directed bench for velocity_estimator.
// WINDOW_LOG2=4, AVG_LOG2=2; vectors plus corner sequences.
module tb_velocity_estimator;
  import motor_pkg::*;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic signed [31:0] position = '0;
  logic signed [31:0] velocity;
  logic signed [31:0] delta;
  logic valid;

  int tests = 0;
  int fails = 0;
  int n = 0;
  logic [31:0] base = '0;
  int stp = 0;

  velocity_estimator #(
    .WINDOW_LOG2(4),
    .AVG_LOG2(2)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .enable  (enable),
    .clear   (clear),
    .position(position),
    .velocity(velocity),
    .delta   (delta),
    .valid   (valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          fresh;
    logic [31:0] b;
    int          s;
    int          at;
    logic [31:0] vel;
    logic [31:0] dlt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm,
               $signed(act), $signed(exp));
    end
  endtask

  // One clock; n counts posedges since the enable edge.
  // Position steps so each TC edge sees base+k*step.
  task automatic tick();
    @(posedge CLK);
    n++;
    @(negedge CLK);
    position = base + 32'(stp * ((n + 1) >> 4));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    base = '0;
    stp = 0;
    position = '0;
    repeat (2) @(negedge CLK);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_vel", velocity, 32'd0);
    chk("rst_dlt", delta, 32'd0);
    reset = 1'b1;
    @(negedge CLK);
    chk("post_rst_valid", {31'b0, valid}, 32'd0);
  endtask

  task automatic begin_run(input logic [31:0] b, input int s);
    base = b;
    stp = s;
    position = b;
    enable = 1'b1;
    n = -1;
    tick();
  endtask

  task automatic wait_strobe(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (valid) begin
        at = n;
        break;
      end
    end
  endtask

  initial begin
    int at;
    bit bad;

    vecs[0]  = '{1, 32'h0, 3, 18, 32'd0, 32'd3};
    vecs[1]  = '{0, 32'h0, 3, 34, 32'd1, 32'd3};
    vecs[2]  = '{0, 32'h0, 3, 50, 32'd2, 32'd3};
    vecs[3]  = '{0, 32'h0, 3, 66, 32'd3, 32'd3};
    vecs[4]  = '{0, 32'h0, 3, 82, 32'd3, 32'd3};
    vecs[5]  = '{1, 32'h7FFFFFFE, 5, 18, 32'd1, 32'd5};
    vecs[6]  = '{0, 32'h7FFFFFFE, 5, 34, 32'd2, 32'd5};
    vecs[7]  = '{0, 32'h7FFFFFFE, 5, 50, 32'd3, 32'd5};
    vecs[8]  = '{0, 32'h7FFFFFFE, 5, 66, 32'd5, 32'd5};
    vecs[9]  = '{1, 32'h0, -7, 18, -32'sd2, -32'sd7};
    vecs[10] = '{0, 32'h0, -7, 34, -32'sd4, -32'sd7};
    vecs[11] = '{0, 32'h0, -7, 50, -32'sd6, -32'sd7};
    vecs[12] = '{0, 32'h0, -7, 66, -32'sd7, -32'sd7};

    // Idle with enable low: nothing moves.
    do_reset();
    base = 32'd1234;
    position = 32'd1234;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid || velocity != 0 || delta != 0) bad = 1;
    end
    chk("idle_quiet", {31'b0, bad}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].fresh) begin
        do_reset();
        begin_run(vecs[i].b, vecs[i].s);
      end
      wait_strobe(40, at);
      chk($sformatf("v%0d_at", i), at, vecs[i].at);
      chk($sformatf("v%0d_vel", i), velocity, vecs[i].vel);
      chk($sformatf("v%0d_dlt", i), delta, vecs[i].dlt);
    end

    // Clear on the TC cycle after three +3 windows.
    do_reset();
    begin_run(32'h0, 3);
    repeat (3) wait_strobe(40, at);
    chk("clr_pre_at", at, 32'd50);
    while (n < 63) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_vel0", velocity, 32'd0);
    chk("clr_dlt0", delta, 32'd0);
    wait_strobe(40, at);
    chk("clr_next_at", at, 32'd82);
    chk("clr_next_vel", velocity, 32'd0);
    chk("clr_next_dlt", delta, 32'd3);

    // Enable dropped mid-window, re-enabled after a jump.
    do_reset();
    begin_run(32'h0, 3);
    wait_strobe(40, at);
    wait_strobe(40, at);
    chk("drop_pre_at", at, 32'd34);
    while (n < 37) tick();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid) bad = 1;
    end
    chk("drop_idle_quiet", {31'b0, bad}, 32'd0);
    begin_run(position + 32'd100, 3);
    wait_strobe(40, at);
    chk("reen_at", at, 32'd18);
    chk("reen_vel", velocity, 32'd2);
    chk("reen_dlt", delta, 32'd3);
    wait_strobe(40, at);
    chk("reen2_vel", velocity, 32'd3);

    // Enable falls right after TC: one trailing strobe only.
    do_reset();
    begin_run(32'h0, 3);
    while (n < 16) tick();
    enable = 1'b0;
    wait_strobe(40, at);
    chk("trail_at", at, 32'd18);
    chk("trail_dlt", delta, 32'd3);
    wait_strobe(40, at);
    chk("trail_none", at, -32'sd1);

    // Reset mid-pipeline kills the pending strobe.
    do_reset();
    begin_run(32'h0, 3);
    while (n < 17) tick();
    reset = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_dlt", delta, 32'd0);
    tick();
    chk("midrst_nostrobe", {31'b0, valid}, 32'd0);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
